vc_pop_arbiter: RTL
===================

# vc_pop_arbiter

Scheduler that drives `pop_delay_vc0` / `pop_delay_vc1` into the two-VC output mux. Each cycle it picks at most one virtual-channel FIFO to pop. A VC is only picked if it holds data and the destination FIFO addressed by its head word is not almost full. VC0 has priority, and a configurable burst limit keeps VC1 from starving. It sits between the VC0/VC1 FIFOs, the D0/D1 destination FIFOs and the mux, and owns the RESET/INIT/IDLE/ACTIVE sequencing of the output stage.

## Interface
Parameters:
- `DATA_SIZE`, 6: width of a VC head word. Bit `DATA_SIZE-1` selects the destination (0 = D0, 1 = D1).
- `BURST_W`, 3: width of the burst limit and of the burst counter.
- `BURST_DEFAULT`, 3: burst limit loaded at reset.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `init` in 1: hold high to stay in INIT and load the config.
- `cfg_burst_max` in `BURST_W`: max consecutive VC0 pops while VC1 is eligible. Sampled in INIT.
- `vc0_empty`, `vc1_empty` in 1 each: VC FIFO empty flags.
- `vc0_head`, `vc1_head` in `DATA_SIZE` each: current head word of each VC FIFO.
- `d0_almost_full`, `d1_almost_full` in 1 each: destination FIFO flags.
- `pop_delay_vc0`, `pop_delay_vc1` out 1 each: pop/enable to the VC FIFOs and the mux. One-hot or zero.
- `idle` out 1: high in state IDLE.
- `active` out 1: high in state ACTIVE.

## Operation
- Eligibility: `eN = !vcN_empty && !(vcN_head[DATA_SIZE-1] ? d1_almost_full : d0_almost_full)`.
- States:
  - RESET: entered while `reset`=1. Goes to INIT on the first cycle with `reset`=0.
  - INIT: `burst_max <= cfg_burst_max` every cycle. Goes to IDLE when `init`=0.
  - IDLE: no pops. Goes to ACTIVE when `e0|e1`; goes to INIT if `init`=1 (init wins).
  - ACTIVE: issues pops. Goes to IDLE in the cycle after `e0|e1`=0. Goes to INIT if `init`=1, and no pop is issued that cycle.
- Grant in ACTIVE (combinational from registered state and counter plus current inputs):
  - Only `e0`: pop VC0.
  - Only `e1`: pop VC1.
  - Both: pop VC0 if `burst_cnt < burst_max`, else pop VC1.
- Burst counter, `BURST_W` bits:
  - Increments on a VC0 pop while `e1`=1, saturating at `burst_max`.
  - Clears on any VC1 pop or any cycle with `e1`=0.
  - Never wraps.
- `burst_max`=0 means VC1 wins every both-eligible cycle.
- Reset values: state RESET, `burst_cnt`=0, `burst_max`=`BURST_DEFAULT`. Outputs `pop_delay_vc0`=0, `pop_delay_vc1`=0, `idle`=0, `active`=0.
- Reset mid-operation: pops drop in the same cycle as `reset`=1 (outputs are gated by the state and by `reset`). Counter and config return to their reset values on the next edge.

## Timing
- Pop latency: same cycle as eligibility while in ACTIVE. No cycle is spent popping a FIFO whose `empty` is currently high.
- IDLE→ACTIVE costs exactly 1 cycle: the first pop comes one cycle after eligibility appears in IDLE.
- The mux registers data one cycle after the pop, so the destination sees `valid_demux_d` at pop+1.
- `*_almost_full` is acted on in the same cycle. The destination FIFO almost-full threshold must leave at least 2 entries of headroom.
- Both `pop_delay_vc*` high at once is illegal and must never occur.

## Structure
- Shared package `vc_pkg`:
  - State encoding `RESET=2'd0`, `INIT=2'd1`, `IDLE=2'd2`, `ACTIVE=2'd3`.
  - The destination-select bit index `DATA_SIZE-1`.
- No sub-module: state register, burst counter and config register live in one module, with one combinational grant block.

## Test plan
- Reset/init sequence: reset 3 cycles, then `init`=1 for 2 cycles with `cfg_burst_max`=2, then `init`=0. Expected: RESET→INIT→IDLE, `idle`=1, no pops, `burst_max`=2.
- Single VC:
  - `vc0_empty`=0, head=6'b0xxxxx, `d0_almost_full`=0: ACTIVE one cycle later, `pop_delay_vc0`=1 every following cycle.
  - Set `d0_almost_full`=1: pop drops in the same cycle, ACTIVE→IDLE on the next edge.
- Anti-starvation: both VCs non-empty, destinations free, `burst_max`=2. Expected pop pattern: VC0, VC0, VC1, VC0, VC0, VC1 …
- Destination blocking: VC0 head targets D1 with `d1_almost_full`=1, VC1 head targets D0 with D0 free. Expected: only VC1 pops; counter stays 0.
- `burst_max`=0 with both eligible: VC1 pops every cycle, VC0 never pops.
- Reset in ACTIVE: assert `reset` mid-burst. Expected: both pops 0 that cycle, state RESET and `burst_cnt`=0 at the next edge, `burst_max`=`BURST_DEFAULT`.

Source files
------------

// File: rtl/vc_pkg.sv
// Shared definitions for the two-VC output stage scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vc_pkg;

  // Output-stage sequencing states; encoding is shared with neighbouring blocks.
  typedef enum logic [1:0] {
    RESET  = 2'd0,
    INIT   = 2'd1,
    IDLE   = 2'd2,
    ACTIVE = 2'd3
  } vc_state_e;

  // Bit of a VC head word that selects the destination FIFO (0 = D0, 1 = D1).
  function automatic int dest_sel_bit(input int data_size);
    return data_size - 1;
  endfunction

endpackage

// File: rtl/vc_pop_arbiter.sv
// Picks at most one of VC0/VC1 to pop per cycle; VC0 priority with a burst cap for VC1 fairness.
// Latency: pop is combinational in ACTIVE; IDLE->ACTIVE costs one cycle.
// Backpressure: destination almost-full masks a VC in the same cycle; empty VCs are never popped.
module vc_pop_arbiter
  import vc_pkg::*;
#(
  parameter int          DATA_SIZE     = 6,
  parameter int          BURST_W       = 3,
  parameter int unsigned BURST_DEFAULT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [BURST_W-1:0]   cfg_burst_max,
  input  logic                 vc0_empty,
  input  logic                 vc1_empty,
  input  logic [DATA_SIZE-1:0] vc0_head,
  input  logic [DATA_SIZE-1:0] vc1_head,
  input  logic                 d0_almost_full,
  input  logic                 d1_almost_full,
  output logic                 pop_delay_vc0,
  output logic                 pop_delay_vc1,
  output logic                 idle,
  output logic                 active
);

  localparam int DSEL = dest_sel_bit(DATA_SIZE);

  vc_state_e          state_q, state_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [BURST_W-1:0] burst_max_q, burst_max_d;

  logic elig0, elig1;
  logic grant0, grant1;

  // A VC is eligible when it has a head word whose destination can take it.
  assign elig0 = !vc0_empty && !(vc0_head[DSEL] ? d1_almost_full : d0_almost_full);
  assign elig1 = !vc1_empty && !(vc1_head[DSEL] ? d1_almost_full : d0_almost_full);

  // Next-state and grant; reset and a pending init both suppress pops immediately.
  always_comb begin
    state_d = state_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
    case (state_q)
      RESET: state_d = INIT;
      INIT: begin
        if (!init) state_d = IDLE;
      end
      IDLE: begin
        if (init)               state_d = INIT;
        else if (elig0 | elig1) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (init) begin
          state_d = INIT;
        end else begin
          if (!(elig0 | elig1)) state_d = IDLE;
          if (elig0 && elig1) begin
            // VC0 keeps the lead until it has used up its burst allowance.
            if (burst_cnt_q < burst_max_q) grant0 = 1'b1;
            else                           grant1 = 1'b1;
          end else begin
            grant0 = elig0;
            grant1 = elig1;
          end
        end
      end
      default: state_d = RESET;
    endcase
    if (reset) begin
      state_d = RESET;
      grant0  = 1'b0;
      grant1  = 1'b0;
    end
  end

  // Burst counter tracks consecutive VC0 wins while VC1 is waiting; config reloads only in INIT.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    burst_max_d = burst_max_q;
    if (grant1 || !elig1) begin
      burst_cnt_d = '0;
    end else if (grant0 && (burst_cnt_q < burst_max_q)) begin
      burst_cnt_d = burst_cnt_q + BURST_W'(1);
    end
    if (state_q == INIT) burst_max_d = cfg_burst_max;
  end

  // State, counter and config registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RESET;
      burst_cnt_q <= '0;
      burst_max_q <= BURST_W'(BURST_DEFAULT);
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      burst_max_q <= burst_max_d;
    end
  end

  assign pop_delay_vc0 = grant0;
  assign pop_delay_vc1 = grant1;
  assign idle          = (state_q == IDLE);
  assign active        = (state_q == ACTIVE);

endmodule
